// File: rtl/modbus_frame_responder.sv
// modbus_frame_responder: slave end of the 48-bit frame link; executes reads/writes on a
// holding-register bank and returns echo, read-reply or exception frames over valid/ready.
module modbus_frame_responder #(
   parameter int SLAVE_ADDR = 2,
   parameter int BASE_ADDR  = 300,
   parameter int NUM_REGS   = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [47:0]            i_rx_data,
   input  logic                   i_rx_valid,
   output logic [47:0]            o_resp_data,
   output logic                   o_resp_valid,
   input  logic                   i_resp_ready,
   output logic [16*NUM_REGS-1:0] o_reg_out,
   output logic                   o_wr_strobe,
   output logic [3:0]             o_wr_index,
   output logic [15:0]            o_frame_cnt,
   output logic [15:0]            o_err_cnt,
   output logic [15:0]            o_ovr_cnt
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      r_state;
   logic [47:0] r_frame;
   logic [15:0] r_bank [NUM_REGS];
   logic [47:0] r_resp_data;
   logic        r_resp_valid;
   logic        r_wr_strobe;
   logic [3:0]  r_wr_index;
   logic [15:0] r_frame_cnt;
   logic [15:0] r_err_cnt;
   logic [15:0] r_ovr_cnt;

   logic [7:0]  w_a;
   logic [7:0]  w_f;
   logic [15:0] w_r;
   logic [15:0] w_v;
   logic [16:0] w_r17;
   logic        w_in_range;
   logic        w_for_us;
   logic [3:0]  w_idx;
   logic [7:0]  w_code;
   logic [15:0] w_rd_val;
   logic [47:0] w_resp;

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return c + 16'(c != 16'hFFFF);
   endfunction

   assign w_a        = r_frame[7:0];
   assign w_f        = r_frame[15:8];
   assign w_r        = r_frame[31:16];
   assign w_v        = r_frame[47:32];
   // 17-bit range compare so addresses near 16'hFFFF cannot wrap into the window
   assign w_r17      = {1'b0, w_r};
   assign w_in_range = w_r17 >= 17'(BASE_ADDR) && w_r17 < 17'(BASE_ADDR + NUM_REGS);
   assign w_for_us   = w_a == 8'(SLAVE_ADDR) || w_a == 8'd0;
   assign w_idx      = 4'(w_r - 16'(BASE_ADDR));
   assign w_code     = (w_f != 8'd3 && w_f != 8'd6) ? 8'h01 :
                       !w_in_range                   ? 8'h02 :
                       (w_f == 8'd3 && w_v != 16'd1) ? 8'h03 : 8'h00;
   assign w_rd_val   = r_bank[w_idx];
   assign w_resp     = w_code != 8'h00 ? {24'h0, w_code, w_f | 8'h80, 8'(SLAVE_ADDR)} :
                       w_f == 8'd6     ? r_frame :
                                         {8'h00, w_rd_val, 8'd2, 8'd3, 8'(SLAVE_ADDR)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_frame      <= '0;
         for (int i = 0; i < NUM_REGS; i++) r_bank[i] <= '0;
         r_resp_data  <= '0;
         r_resp_valid <= 1'b0;
         r_wr_strobe  <= 1'b0;
         r_wr_index   <= '0;
         r_frame_cnt  <= '0;
         r_err_cnt    <= '0;
         r_ovr_cnt    <= '0;
      end else begin
         r_wr_strobe <= 1'b0;
         if (i_rx_valid && r_state != IDLE) r_ovr_cnt <= sat_inc(r_ovr_cnt);
         case (r_state)
            IDLE: if (i_rx_valid) begin
               r_frame <= i_rx_data;
               r_state <= EXEC;
            end
            EXEC: begin
               r_state <= IDLE;
               if (w_for_us) begin
                  r_frame_cnt <= sat_inc(r_frame_cnt);
                  if (w_code == 8'h00 && w_f == 8'd6) begin
                     r_bank[w_idx] <= w_v;
                     r_wr_strobe   <= 1'b1;
                     r_wr_index    <= w_idx;
                  end
                  // broadcasts never answer, not even with an exception
                  if (w_a != 8'd0) begin
                     r_resp_data  <= w_resp;
                     r_resp_valid <= 1'b1;
                     r_state      <= RESP;
                     if (w_code != 8'h00) r_err_cnt <= sat_inc(r_err_cnt);
                  end
               end
            end
            RESP: if (i_resp_ready) begin
               r_resp_valid <= 1'b0;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
      assign o_reg_out[16*k +: 16] = r_bank[k];
   end

   assign o_resp_data  = r_resp_data;
   assign o_resp_valid = r_resp_valid;
   assign o_wr_strobe  = r_wr_strobe;
   assign o_wr_index   = r_wr_index;
   assign o_frame_cnt  = r_frame_cnt;
   assign o_err_cnt    = r_err_cnt;
   assign o_ovr_cnt    = r_ovr_cnt;
endmodule

// File: tb/tb_modbus_frame_responder.sv
// tb_modbus_frame_responder: behavioural reference model plus directed and random frames
// against the frame responder, checked every cycle.
module tb_modbus_frame_responder;
   localparam int SA = 2;
   localparam int BASE = 300;
   localparam int N = 10;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [47:0]    i_rx_data = '0;
   logic           i_rx_valid = 1'b0;
   logic           i_resp_ready = 1'b1;
   logic [47:0]    o_resp_data;
   logic           o_resp_valid;
   logic [16*N-1:0] o_reg_out;
   logic           o_wr_strobe;
   logic [3:0]     o_wr_index;
   logic [15:0]    o_frame_cnt, o_err_cnt, o_ovr_cnt;

   int n_checks = 0;
   int n_fail = 0;

   modbus_frame_responder #(.SLAVE_ADDR(SA), .BASE_ADDR(BASE), .NUM_REGS(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
      .o_resp_data(o_resp_data), .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
      .o_reg_out(o_reg_out), .o_wr_strobe(o_wr_strobe), .o_wr_index(o_wr_index),
      .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt), .o_ovr_cnt(o_ovr_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [47:0] mk(input int a, input int f, input int r, input int v);
      return {16'(v), 16'(r), 8'(f), 8'(a)};
   endfunction

   // Reference model: transaction-level view (pending frame, pending response, bank array)
   logic [15:0] m_bank [N];
   logic        m_exec, m_rv, m_ws;
   logic [47:0] m_frame, m_rd;
   int          m_wi, m_fc, m_ec, m_oc;

   function automatic int sat(input int c);
      return c >= 65535 ? 65535 : c + 1;
   endfunction

   task automatic model_exec(input logic [47:0] fr);
      int a, f, r, v, code;
      a = int'(fr[7:0]);
      f = int'(fr[15:8]);
      r = int'(fr[31:16]);
      v = int'(fr[47:32]);
      if (a != SA && a != 0) return;
      m_fc = sat(m_fc);
      if (f != 3 && f != 6) code = 1;
      else if (r < BASE || r >= BASE + N) code = 2;
      else if (f == 3 && v != 1) code = 3;
      else code = 0;
      if (code == 0 && f == 6) begin
         m_bank[r - BASE] = 16'(v);
         m_ws = 1'b1;
         m_wi = r - BASE;
      end
      if (a == 0) return;
      m_rv = 1'b1;
      if (code != 0) begin
         m_ec = sat(m_ec);
         m_rd = {24'h0, 8'(code), 8'(f) | 8'h80, 8'(SA)};
      end else if (f == 6) m_rd = fr;
      else m_rd = {8'h00, m_bank[r - BASE], 8'd2, 8'd3, 8'(SA)};
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) m_bank[i] = '0;
         m_exec = 0; m_rv = 0; m_ws = 0; m_frame = '0; m_rd = '0;
         m_wi = 0; m_fc = 0; m_ec = 0; m_oc = 0;
      end else begin
         m_ws = 1'b0;
         if (i_rx_valid && (m_exec || m_rv)) m_oc = sat(m_oc);
         if (m_exec) begin
            m_exec = 1'b0;
            model_exec(m_frame);
         end else if (m_rv) begin
            if (i_resp_ready) m_rv = 1'b0;
         end else if (i_rx_valid) begin
            m_frame = i_rx_data;
            m_exec = 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      logic [16*N-1:0] exp_regs;
      #1;
      if (rst_n) begin
         for (int i = 0; i < N; i++) exp_regs[16*i +: 16] = m_bank[i];
         chk("resp_valid", 160'(o_resp_valid), 160'(m_rv));
         if (m_rv) chk("resp_data", 160'(o_resp_data), 160'(m_rd));
         chk("reg_out", 160'(o_reg_out), 160'(exp_regs));
         chk("wr_strobe", 160'(o_wr_strobe), 160'(m_ws));
         chk("wr_index", 160'(o_wr_index), 160'(m_wi));
         chk("frame_cnt", 160'(o_frame_cnt), 160'(m_fc));
         chk("err_cnt", 160'(o_err_cnt), 160'(m_ec));
         chk("ovr_cnt", 160'(o_ovr_cnt), 160'(m_oc));
      end
   end

   task automatic send(input logic [47:0] fr);
      i_rx_valid = 1'b1;
      i_rx_data = fr;
      @(negedge clk);
      i_rx_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_resp_valid", 160'(o_resp_valid), 160'd0);
      chk("rst_reg_out", 160'(o_reg_out), 160'd0);
      chk("rst_frame_cnt", 160'(o_frame_cnt), 160'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // write then read
      send(mk(SA, 6, 303, 16'h1234));
      chk("wr_strobe_lit", 160'(o_wr_strobe), 160'd1);
      chk("wr_index_lit", 160'(o_wr_index), 160'd3);
      chk("reg3_lit", 160'(o_reg_out[63:48]), 160'h1234);
      chk("echo_lit", 160'(o_resp_data), 160'(48'h1234_012F_0602));
      chk("frame_cnt_lit", 160'(o_frame_cnt), 160'd1);
      @(negedge clk);
      send(mk(SA, 3, 303, 1));
      chk("read_val_lit", 160'(o_resp_data[39:24]), 160'h1234);
      chk("read_bc_lit", 160'(o_resp_data[23:16]), 160'd2);
      chk("read_fn_lit", 160'(o_resp_data[15:8]), 160'd3);
      @(negedge clk);

      // exceptions
      send(mk(SA, 5, 300, 0));
      chk("exc1_hdr", 160'(o_resp_data[15:0]), 160'h8502);
      chk("exc1_code", 160'(o_resp_data[23:16]), 160'h01);
      chk("exc1_err", 160'(o_err_cnt), 160'd1);
      @(negedge clk);
      send(mk(SA, 6, 310, 7));
      chk("exc2_code", 160'(o_resp_data[23:16]), 160'h02);
      chk("exc2_fn", 160'(o_resp_data[15:8]), 160'h86);
      @(negedge clk);
      send(mk(SA, 3, 301, 2));
      chk("exc3_code", 160'(o_resp_data[23:16]), 160'h03);
      @(negedge clk);
      send(mk(SA, 7, 999, 1));
      chk("exc_prio", 160'(o_resp_data), 160'(48'h0000_0001_8702));
      @(negedge clk);

      // address filtering and broadcast
      send(mk(5, 6, 301, 16'h5A5A));
      chk("foreign_nores", 160'(o_resp_valid), 160'd0);
      chk("foreign_cnt", 160'(o_frame_cnt), 160'd6);
      send(mk(0, 6, 309, 16'hBEEF));
      chk("bcast_reg9", 160'(o_reg_out[159:144]), 160'hBEEF);
      chk("bcast_nores", 160'(o_resp_valid), 160'd0);
      chk("bcast_cnt", 160'(o_frame_cnt), 160'd7);

      // boundaries
      send(mk(SA, 3, 300, 1));
      chk("bnd300", 160'(o_resp_data[23:8]), 160'h0203);
      @(negedge clk);
      send(mk(SA, 3, 309, 1));
      chk("bnd309", 160'(o_resp_data), 160'(48'h00BE_EF02_0302));
      @(negedge clk);
      send(mk(SA, 3, 299, 1));
      chk("bnd299", 160'(o_resp_data[23:8]), 160'h0283);
      @(negedge clk);
      send(mk(SA, 3, 310, 1));
      chk("bnd310", 160'(o_resp_data[23:8]), 160'h0283);
      @(negedge clk);

      // backpressure with a busy drop in the middle
      i_resp_ready = 1'b0;
      send(mk(SA, 3, 309, 1));
      for (int c = 0; c < 20; c++) begin
         chk("bp_stable", 160'(o_resp_data), 160'(48'h00BE_EF02_0302));
         chk("bp_valid", 160'(o_resp_valid), 160'd1);
         i_rx_valid = (c == 5);
         i_rx_data = mk(SA, 6, 300, 16'hDEAD);
         @(negedge clk);
      end
      i_rx_valid = 1'b0;
      chk("bp_ovr", 160'(o_ovr_cnt), 160'd1);
      chk("bp_bank0", 160'(o_reg_out[15:0]), 160'd0);
      i_resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_done", 160'(o_resp_valid), 160'd0);

      // reset while a response is pending
      i_resp_ready = 1'b0;
      send(mk(SA, 3, 303, 1));
      chk("pre_rst_valid", 160'(o_resp_valid), 160'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 160'(o_resp_valid), 160'd0);
      chk("mid_rst_regs", 160'(o_reg_out), 160'd0);
      chk("mid_rst_cnts", 160'({o_frame_cnt, o_err_cnt, o_ovr_cnt}), 160'd0);
      @(negedge clk);
      rst_n = 1'b1;
      i_resp_ready = 1'b1;
      @(negedge clk);
      send(mk(SA, 6, 305, 16'h5555));
      chk("post_rst_reg5", 160'(o_reg_out[95:80]), 160'h5555);
      chk("post_rst_cnt", 160'(o_frame_cnt), 160'd1);
      @(negedge clk);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int a, f, r, v;
         a = ($urandom_range(0, 5) == 0) ? 0 : ($urandom_range(0, 7) == 0) ? 5 : SA;
         f = ($urandom_range(0, 7) == 0) ? 5 : ($urandom_range(0, 1) == 0) ? 3 : 6;
         r = $urandom_range(BASE - 2, BASE + N + 1);
         v = (f == 3 && $urandom_range(0, 5) != 0) ? 1 : int'($urandom_range(0, 65535));
         i_rx_valid = ($urandom_range(0, 2) == 0);
         i_rx_data = mk(a, f, r, v);
         i_resp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      i_rx_valid = 1'b0;
      i_resp_ready = 1'b1;
      repeat (4) @(negedge clk);

      // drive ovr_cnt into saturation while a response is held
      i_resp_ready = 1'b0;
      send(mk(SA, 3, 300, 1));
      i_rx_valid = 1'b1;
      repeat (65540) @(negedge clk);
      i_rx_valid = 1'b0;
      chk("ovr_sat", 160'(o_ovr_cnt), 160'hFFFF);
      i_resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("ovr_sat_hold", 160'(o_ovr_cnt), 160'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
